// File: rtl/algo_2rw_port_sched_if.sv
// Requester-side bus of the two-port scheduler: packed per-requester request
// fields, accept strobes and read responses (requester 0 in the LSBs).
interface algo_2rw_port_sched_if #(
   parameter int NUMREQ  = 4,
   parameter int BITADDR = 13,
   parameter int WIDTH   = 32
);
   logic [NUMREQ-1:0]         req_vld;
   logic [NUMREQ-1:0]         req_write;
   logic [NUMREQ*BITADDR-1:0] req_addr;
   logic [NUMREQ*WIDTH-1:0]   req_din;
   logic [NUMREQ*WIDTH-1:0]   req_bw;
   logic [NUMREQ-1:0]         req_rdy;
   logic [NUMREQ-1:0]         rsp_vld;
   logic [NUMREQ*WIDTH-1:0]   rsp_dout;

   modport master (
      output req_vld, req_write, req_addr, req_din, req_bw,
      input  req_rdy, rsp_vld, rsp_dout
   );

   modport slave (
      input  req_vld, req_write, req_addr, req_din, req_bw,
      output req_rdy, rsp_vld, rsp_dout
   );
endinterface

// File: rtl/algo_2rw_port_sched.sv
// Round-robin scheduler mapping up to NUMREQ requesters onto the two RW ports of t1.
// Optional conflict-stall counter: define ALGO_2RW_SCHED_STALL_CNT_EN.
module algo_2rw_port_sched #(
   parameter int WIDTH      = 32,
   parameter int BITADDR    = 13,
   parameter int NUMREQ     = 4,
   parameter int BITREQ     = 2,
   parameter int SRAM_DELAY = 1
) (
   input  logic                clk,
   input  logic                rst,
   algo_2rw_port_sched_if.slave req_if,
   output logic                t1_readA_o,
   output logic                t1_writeA_o,
   output logic [BITADDR-1:0]  t1_addrA_o,
   output logic [WIDTH-1:0]    t1_dinA_o,
   output logic [WIDTH-1:0]    t1_bwA_o,
   input  logic [WIDTH-1:0]    t1_doutA_i,
   output logic                t1_readB_o,
   output logic                t1_writeB_o,
   output logic [BITADDR-1:0]  t1_addrB_o,
   output logic [WIDTH-1:0]    t1_dinB_o,
   output logic [WIDTH-1:0]    t1_bwB_o,
   input  logic [WIDTH-1:0]    t1_doutB_i,
   output logic [15:0]         stall_cnt_o
);

   localparam int unsigned NREQ_U = NUMREQ;

   function automatic logic [BITREQ-1:0] wrap_add(input logic [BITREQ-1:0] base,
                                                  input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      return BITREQ'(sum % NREQ_U);
   endfunction

   logic [BITREQ-1:0]  ptr_q, ptr_d;
   logic               gnt_a_s, cand_b_s, gnt_b_s, conflict_s;
   logic [BITREQ-1:0]  idx_a_s, idx_b_s;
   logic               wr_a_s, wr_b_s;
   logic [BITADDR-1:0] addr_a_s, addr_b_s;
   logic [WIDTH-1:0]   din_a_s, din_b_s, bw_a_s, bw_b_s;
   logic [NUMREQ-1:0]  rdy_s;

   logic               rd_a_q, wr_a_q, rd_b_q, wr_b_q;
   logic               rd_a_d, wr_a_d, rd_b_d, wr_b_d;
   logic [BITADDR-1:0] addr_a_q, addr_b_q, addr_a_d, addr_b_d;
   logic [WIDTH-1:0]   din_a_q, din_b_q, din_a_d, din_b_d;
   logic [WIDTH-1:0]   bw_a_q, bw_b_q, bw_a_d, bw_b_d;

   // Per-stage one-hot requester tags; src_b marks data returning on port B.
   logic [SRAM_DELAY:0][NUMREQ-1:0] tag_vld_q, tag_vld_d;
   logic [SRAM_DELAY:0][NUMREQ-1:0] tag_srcb_q, tag_srcb_d;
   logic [NUMREQ*WIDTH-1:0]         hold_q, hold_d, rsp_dout_s;

   // Port A candidate: first valid requester at or after the pointer; B: next valid after A.
   always_comb begin
      logic [BITREQ-1:0] j;
      gnt_a_s  = 1'b0;
      cand_b_s = 1'b0;
      idx_a_s  = '0;
      idx_b_s  = '0;
      j        = '0;
      for (int k = 0; k < NUMREQ; k++) begin
         j = wrap_add(ptr_q, unsigned'(k));
         if (!gnt_a_s && req_if.req_vld[j]) begin
            gnt_a_s = 1'b1;
            idx_a_s = j;
         end else begin
            gnt_a_s = gnt_a_s;
         end
      end
      for (int k = 1; k < NUMREQ; k++) begin
         j = wrap_add(idx_a_s, unsigned'(k));
         if (gnt_a_s && !cand_b_s && req_if.req_vld[j]) begin
            cand_b_s = 1'b1;
            idx_b_s  = j;
         end else begin
            cand_b_s = cand_b_s;
         end
      end
   end

   assign wr_a_s   = req_if.req_write[idx_a_s];
   assign wr_b_s   = req_if.req_write[idx_b_s];
   assign addr_a_s = req_if.req_addr[idx_a_s*BITADDR +: BITADDR];
   assign addr_b_s = req_if.req_addr[idx_b_s*BITADDR +: BITADDR];
   assign din_a_s  = req_if.req_din[idx_a_s*WIDTH +: WIDTH];
   assign din_b_s  = req_if.req_din[idx_b_s*WIDTH +: WIDTH];
   assign bw_a_s   = req_if.req_bw[idx_a_s*WIDTH +: WIDTH];
   assign bw_b_s   = req_if.req_bw[idx_b_s*WIDTH +: WIDTH];

   // Same-word access with a write on either side must be serialised.
   assign conflict_s = cand_b_s && (addr_a_s == addr_b_s) && (wr_a_s || wr_b_s);
   assign gnt_b_s    = cand_b_s && !conflict_s;

   // Accept strobes, forced low while reset is held.
   always_comb begin
      rdy_s = '0;
      if (rst) begin
         rdy_s = '0;
      end else begin
         if (gnt_a_s) begin
            rdy_s[idx_a_s] = 1'b1;
         end else begin
            rdy_s = rdy_s;
         end
         if (gnt_b_s) begin
            rdy_s[idx_b_s] = 1'b1;
         end else begin
            rdy_s = rdy_s;
         end
      end
   end

   assign req_if.req_rdy = rdy_s;

   // Pointer moves just past the last granted requester in round-robin order.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_b_s) begin
         ptr_d = wrap_add(idx_b_s, 32'd1);
      end else if (gnt_a_s) begin
         ptr_d = wrap_add(idx_a_s, 32'd1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Next-cycle t1 commands; an idle port drives all-zero.
   always_comb begin
      rd_a_d   = gnt_a_s && !wr_a_s;
      wr_a_d   = gnt_a_s && wr_a_s;
      addr_a_d = gnt_a_s ? addr_a_s : '0;
      din_a_d  = gnt_a_s ? din_a_s  : '0;
      bw_a_d   = gnt_a_s ? bw_a_s   : '0;
      rd_b_d   = gnt_b_s && !wr_b_s;
      wr_b_d   = gnt_b_s && wr_b_s;
      addr_b_d = gnt_b_s ? addr_b_s : '0;
      din_b_d  = gnt_b_s ? din_b_s  : '0;
      bw_b_d   = gnt_b_s ? bw_b_s   : '0;
   end

   // Read tags enter at acceptance and surface SRAM_DELAY+1 cycles later.
   always_comb begin
      tag_vld_d  = '0;
      tag_srcb_d = '0;
      if (rd_a_d) begin
         tag_vld_d[0][idx_a_s] = 1'b1;
      end else begin
         tag_vld_d[0] = tag_vld_d[0];
      end
      if (rd_b_d) begin
         tag_vld_d[0][idx_b_s]  = 1'b1;
         tag_srcb_d[0][idx_b_s] = 1'b1;
      end else begin
         tag_srcb_d[0] = tag_srcb_d[0];
      end
      for (int i = 1; i <= SRAM_DELAY; i++) begin
         tag_vld_d[i]  = tag_vld_q[i-1];
         tag_srcb_d[i] = tag_srcb_q[i-1];
      end
   end

   // Response slots pass returning t1 data through and otherwise hold.
   always_comb begin
      rsp_dout_s = hold_q;
      for (int i = 0; i < NUMREQ; i++) begin
         if (tag_vld_q[SRAM_DELAY][i]) begin
            rsp_dout_s[i*WIDTH +: WIDTH] = tag_srcb_q[SRAM_DELAY][i] ? t1_doutB_i : t1_doutA_i;
         end else begin
            rsp_dout_s[i*WIDTH +: WIDTH] = hold_q[i*WIDTH +: WIDTH];
         end
      end
      hold_d = rsp_dout_s;
   end

   assign req_if.rsp_vld  = tag_vld_q[SRAM_DELAY];
   assign req_if.rsp_dout = rsp_dout_s;

   // Scheduler state, t1 command registers and tag pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         rd_a_q     <= 1'b0;
         wr_a_q     <= 1'b0;
         addr_a_q   <= '0;
         din_a_q    <= '0;
         bw_a_q     <= '0;
         rd_b_q     <= 1'b0;
         wr_b_q     <= 1'b0;
         addr_b_q   <= '0;
         din_b_q    <= '0;
         bw_b_q     <= '0;
         tag_vld_q  <= '0;
         tag_srcb_q <= '0;
         hold_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rd_a_q     <= rd_a_d;
         wr_a_q     <= wr_a_d;
         addr_a_q   <= addr_a_d;
         din_a_q    <= din_a_d;
         bw_a_q     <= bw_a_d;
         rd_b_q     <= rd_b_d;
         wr_b_q     <= wr_b_d;
         addr_b_q   <= addr_b_d;
         din_b_q    <= din_b_d;
         bw_b_q     <= bw_b_d;
         tag_vld_q  <= tag_vld_d;
         tag_srcb_q <= tag_srcb_d;
         hold_q     <= hold_d;
      end
   end

   assign t1_readA_o  = rd_a_q;
   assign t1_writeA_o = wr_a_q;
   assign t1_addrA_o  = addr_a_q;
   assign t1_dinA_o   = din_a_q;
   assign t1_bwA_o    = bw_a_q;
   assign t1_readB_o  = rd_b_q;
   assign t1_writeB_o = wr_b_q;
   assign t1_addrB_o  = addr_b_q;
   assign t1_dinB_o   = din_b_q;
   assign t1_bwB_o    = bw_b_q;

`ifdef ALGO_2RW_SCHED_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles in which the second grant was withheld.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (conflict_s && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_algo_2rw_port_sched.sv
// Self-checking bench for algo_2rw_port_sched: directed vector table, hand sequences,
// and random traffic checked against a queue-based reference model.
module tb_algo_2rw_port_sched;
   localparam int WIDTH = 32, BITADDR = 13, NUMREQ = 4, BITREQ = 2, SD = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   algo_2rw_port_sched_if #(.NUMREQ(NUMREQ), .BITADDR(BITADDR), .WIDTH(WIDTH)) bus ();

   logic               t1_readA, t1_writeA, t1_readB, t1_writeB;
   logic [BITADDR-1:0] t1_addrA, t1_addrB;
   logic [WIDTH-1:0]   t1_dinA, t1_bwA, t1_dinB, t1_bwB, t1_doutA, t1_doutB;
   logic [15:0]        stall_cnt;

   algo_2rw_port_sched #(.WIDTH(WIDTH), .BITADDR(BITADDR), .NUMREQ(NUMREQ),
                         .BITREQ(BITREQ), .SRAM_DELAY(SD)) dut (
      .clk(clk), .rst(rst), .req_if(bus),
      .t1_readA_o(t1_readA), .t1_writeA_o(t1_writeA), .t1_addrA_o(t1_addrA),
      .t1_dinA_o(t1_dinA), .t1_bwA_o(t1_bwA), .t1_doutA_i(t1_doutA),
      .t1_readB_o(t1_readB), .t1_writeB_o(t1_writeB), .t1_addrB_o(t1_addrB),
      .t1_dinB_o(t1_dinB), .t1_bwB_o(t1_bwB), .t1_doutB_i(t1_doutB),
      .stall_cnt_o(stall_cnt)
   );

   function automatic logic [31:0] data_fn(input logic [BITADDR-1:0] a);
      if (a == 13'h10) return 32'hDEADBEEF;
      return 32'hC3A5_0000 ^ {a, 6'd0, a};
   endfunction

   // Memory model: data for an address appears one cycle after it is presented.
   logic [BITADDR-1:0] adA_q, adB_q;
   always @(posedge clk) begin
      adA_q <= t1_addrA;
      adB_q <= t1_addrB;
   end
   assign t1_doutA = data_fn(adA_q);
   assign t1_doutB = data_fn(adB_q);

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Stimulus
   logic [NUMREQ-1:0]         s_vld, s_wr;
   logic [NUMREQ*BITADDR-1:0] s_addr;
   logic [NUMREQ*WIDTH-1:0]   s_din, s_bw;
   logic [NUMREQ-1:0]         obs_rdy;

   // Reference model state
   typedef struct {
      int          due;
      int          id;
      logic [31:0] data;
   } pend_t;
   pend_t       pend[$];
   int          cyc;
   int          m_ptr;
   logic [15:0] m_stall;
   logic [78:0] e_A, e_B;
   logic [31:0] last_d [NUMREQ];

   task automatic model_reset();
      m_ptr = 0; m_stall = 16'h0; e_A = '0; e_B = '0; pend.delete();
      for (int i = 0; i < NUMREQ; i++) last_d[i] = 32'h0;
   endtask

   task automatic drive();
      bus.req_vld = s_vld; bus.req_write = s_wr; bus.req_addr = s_addr;
      bus.req_din = s_din; bus.req_bw = s_bw;
   endtask

   // One clock cycle: apply stimulus, check at negedge, advance model at posedge.
   task automatic run_cycle();
      int order[$];
      bit ga, gb, cf;
      int ia, ib;
      logic [NUMREQ-1:0]       erdy, ev;
      logic [NUMREQ*WIDTH-1:0] ed;
      drive();
      @(negedge clk);
      for (int k = 0; k < NUMREQ; k++)
         if (s_vld[(m_ptr + k) % NUMREQ]) order.push_back((m_ptr + k) % NUMREQ);
      ga = order.size() > 0; gb = 1'b0; cf = 1'b0; ia = 0; ib = 0;
      if (ga) ia = order[0];
      if (order.size() > 1) begin
         ib = order[1];
         cf = (s_addr[ia*BITADDR +: BITADDR] == s_addr[ib*BITADDR +: BITADDR]) && (s_wr[ia] || s_wr[ib]);
         gb = !cf;
      end
      erdy = '0;
      if (ga) erdy[ia] = 1'b1;
      if (gb) erdy[ib] = 1'b1;
      ev = '0;
      for (int i = 0; i < NUMREQ; i++) ed[i*WIDTH +: WIDTH] = last_d[i];
      foreach (pend[p]) if (pend[p].due == cyc) begin
         ev[pend[p].id] = 1'b1;
         ed[pend[p].id*WIDTH +: WIDTH] = pend[p].data;
      end
      obs_rdy = bus.req_rdy;
      chk("req_rdy", bus.req_rdy, erdy);
      chk("t1_portA", {t1_readA, t1_writeA, t1_addrA, t1_dinA, t1_bwA}, e_A);
      chk("t1_portB", {t1_readB, t1_writeB, t1_addrB, t1_dinB, t1_bwB}, e_B);
      chk("rsp_vld", bus.rsp_vld, ev);
      chk("rsp_dout", bus.rsp_dout, ed);
      chk("stall_cnt", stall_cnt, m_stall);
      @(posedge clk);
`ifdef ALGO_2RW_SCHED_STALL_CNT_EN
      if (cf && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      while (pend.size() > 0 && pend[0].due == cyc) begin
         last_d[pend[0].id] = pend[0].data;
         void'(pend.pop_front());
      end
      e_A = ga ? {!s_wr[ia], s_wr[ia], s_addr[ia*BITADDR +: BITADDR], s_din[ia*WIDTH +: WIDTH],
                  s_bw[ia*WIDTH +: WIDTH]} : '0;
      e_B = gb ? {!s_wr[ib], s_wr[ib], s_addr[ib*BITADDR +: BITADDR], s_din[ib*WIDTH +: WIDTH],
                  s_bw[ib*WIDTH +: WIDTH]} : '0;
      if (ga && !s_wr[ia]) pend.push_back('{cyc + SD + 1, ia, data_fn(s_addr[ia*BITADDR +: BITADDR])});
      if (gb && !s_wr[ib]) pend.push_back('{cyc + SD + 1, ib, data_fn(s_addr[ib*BITADDR +: BITADDR])});
      if (gb) m_ptr = (ib + 1) % NUMREQ;
      else if (ga) m_ptr = (ia + 1) % NUMREQ;
      cyc++;
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_rdy"}, bus.req_rdy, 4'b0000);
      chk({tag, "_t1"}, {t1_readA, t1_writeA, t1_addrA, t1_dinA, t1_bwA,
                         t1_readB, t1_writeB, t1_addrB, t1_dinB, t1_bwB}, 158'd0);
      chk({tag, "_rsp_vld"}, bus.rsp_vld, 4'b0000);
   endtask

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  wr;
      logic [51:0] addr;
      logic [3:0]  rdy;
   } vec_t;
   vec_t vt [12];

   initial begin
      vt[0]  = '{4'b1111, 4'b0000, {13'd4, 13'd3, 13'd2, 13'd1}, 4'b0011};
      vt[1]  = '{4'b1111, 4'b0000, {13'd4, 13'd3, 13'd2, 13'd1}, 4'b1100};
      vt[2]  = '{4'b0011, 4'b0001, {13'h0, 13'h0, 13'h20, 13'h20}, 4'b0001};
      vt[3]  = '{4'b0010, 4'b0000, {13'h0, 13'h0, 13'h20, 13'h0}, 4'b0010};
      vt[4]  = '{4'b1010, 4'b0000, {13'h30, 13'h0, 13'h30, 13'h0}, 4'b1010};
      vt[5]  = '{4'b0101, 4'b0100, {13'h0, 13'h40, 13'h0, 13'h40}, 4'b0100};
      vt[6]  = '{4'b0001, 4'b0001, {13'h0, 13'h0, 13'h0, 13'h5}, 4'b0001};
      vt[7]  = '{4'b0000, 4'b0000, {13'h0, 13'h0, 13'h0, 13'h0}, 4'b0000};
      vt[8]  = '{4'b1001, 4'b1001, {13'd7, 13'd0, 13'd0, 13'd6}, 4'b1001};
      vt[9]  = '{4'b1111, 4'b1111, {13'd11, 13'd10, 13'd9, 13'd8}, 4'b0110};
      vt[10] = '{4'b1111, 4'b0000, {13'd1, 13'd1, 13'd1, 13'd1}, 4'b1001};
      vt[11] = '{4'b0110, 4'b0110, {13'd0, 13'd3, 13'd3, 13'd0}, 4'b0010};

      // Reset with every requester asking: nothing may be accepted.
      rst = 1'b1; s_vld = 4'b1111; s_wr = '0; s_addr = '0; s_din = '0; s_bw = '0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      chk("reset_rsp_dout", bus.rsp_dout, 128'd0);
      chk("reset_stall", stall_cnt, 16'h0);
      s_vld = '0; drive();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      model_reset(); cyc = 0;

      // Directed table: pointer progression, conflicts, read/read sharing.
      for (int v = 0; v < 12; v++) begin
         s_vld = vt[v].vld; s_wr = vt[v].wr; s_addr = vt[v].addr;
         s_din = {$urandom, $urandom, $urandom, $urandom};
         s_bw  = {$urandom, $urandom, $urandom, $urandom};
         run_cycle();
         chk($sformatf("vec%0d_rdy", v), obs_rdy, vt[v].rdy);
      end

      // Read on requester 2 of address 0x10: t1 read next cycle, response the cycle after.
      s_vld = 4'b0000; run_cycle();
      s_vld = 4'b0100; s_wr = 4'b0000; s_addr = {13'h0, 13'h10, 13'h0, 13'h0};
      run_cycle();
      chk("rd_t1_readA", t1_readA, 1'b1);
      chk("rd_t1_addrA", t1_addrA, 13'h10);
      s_vld = 4'b0000; run_cycle();
      chk("rd_rsp_vld", bus.rsp_vld, 4'b0100);
      chk("rd_rsp_dout2", bus.rsp_dout[95:64], 32'hDEADBEEF);
      run_cycle();
      chk("rd_rsp_hold", bus.rsp_dout[95:64], 32'hDEADBEEF);

      // Random traffic on a small address set to provoke conflicts.
      for (int n = 0; n < 400; n++) begin
         s_vld = 4'($urandom); s_wr = 4'($urandom);
         for (int i = 0; i < NUMREQ; i++) s_addr[i*BITADDR +: BITADDR] = 13'($urandom_range(0, 3));
         s_din = {$urandom, $urandom, $urandom, $urandom};
         s_bw  = {$urandom, $urandom, $urandom, $urandom};
         run_cycle();
      end

      // Reset pulse while a read is in flight: its response must never appear.
      s_vld = 4'b0001; s_wr = 4'b0000; s_addr = {13'h0, 13'h0, 13'h0, 13'h11};
      run_cycle();
      rst = 1'b1; s_vld = 4'b1111; drive(); #1;
      check_idle_outputs("midrst_a");
      @(posedge clk); #1;
      check_idle_outputs("midrst_b");
      s_vld = 4'b0000; drive();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
      for (int n = 0; n < 4; n++) run_cycle();

`ifdef ALGO_2RW_SCHED_STALL_CNT_EN
      // Continuous write/read collision on one address saturates the stall counter.
      s_vld = 4'b0011; s_wr = 4'b0001; s_addr = {13'h0, 13'h0, 13'h20, 13'h20};
      for (int n = 0; n < 70000; n++) run_cycle();
      chk("stall_sat", stall_cnt, 16'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/algo_2rw_port_sched.md
ALGO_2RW_PORT_SCHED -- requirements
Module: algo_2rw_port_sched

Interface
REQ-001 SHALL have parameter WIDTH, 32, data/byte-write-mask width per word.
REQ-002 SHALL have parameter BITADDR, 13, address width.
REQ-003 SHALL have parameter NUMREQ, 4, number of requesters (2..8).
REQ-004 SHALL have parameter BITREQ, 2, clog2(NUMREQ).
REQ-005 SHALL have parameter SRAM_DELAY, 1, memory read latency in cycles from registered t1 read to t1_dout valid (0..4).
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports req_vld/req_write  input  NUMREQ  per-requester request valid / write (0 = read).
REQ-009 SHALL have ports req_addr  input  NUMREQ*BITADDR, req_din/req_bw  input  NUMREQ*WIDTH, packed, requester 0 in LSBs.
REQ-010 SHALL have port req_rdy  output  NUMREQ  request accepted this cycle.
REQ-011 SHALL have ports rsp_vld  output  NUMREQ  one-hot-per-port read-data valid, and rsp_dout  output  NUMREQ*WIDTH  read data.
REQ-012 SHALL have ports t1_readA/t1_writeA  output  1, t1_addrA  output  BITADDR, t1_dinA/t1_bwA  output  WIDTH, t1_doutA  input  WIDTH; identical B set.
REQ-013 SHALL have port stall_cnt  output  16  conflict-stall counter (see Configuration).

Function
REQ-014 SHALL accept a request when req_vld & req_rdy in same cycle; req_rdy combinational from req_vld, pointer and conflict check.
REQ-015 SHALL grant at most two requests per cycle: first valid requester at/after round-robin pointer to port A, next valid one (wrapping modulo NUMREQ) to port B.
REQ-016 SHALL withhold the second grant when both target the same address and either is a write; second requester waits (conflict stall).
REQ-017 SHALL advance pointer to (last granted index + 1) mod NUMREQ; pointer unchanged when no grant.
REQ-018 SHALL register port A/B command, address, din, bw one cycle after acceptance; ungranted port drives read=write=0, addr/din/bw=0.
REQ-019 SHALL carry requester id plus valid per port through a SRAM_DELAY+1 deep tag pipeline, only for reads.
REQ-020 SHALL assert rsp_vld[id] with t1_doutA/B data in rsp_dout slot id exactly SRAM_DELAY+1 cycles after read acceptance; no response for writes.
REQ-021 SHALL hold rsp_dout slot at last value when its rsp_vld is low.
REQ-022 SHALL never grant both ports to one requester in the same cycle.
REQ-023 SHALL sustain two accepted requests per cycle with no bubbles when no conflict.

Reset
REQ-024 SHALL on rst clear pointer to 0, all t1 read/write/addr/din/bw to 0, rsp_vld to 0, rsp_dout to 0, tag pipeline valids to 0, stall_cnt to 0.
REQ-025 SHALL drop in-flight reads when rst asserts mid-operation; no rsp_vld after rst deassertion for pre-reset requests.
REQ-026 SHALL drive req_rdy to 0 while rst is high.

Configuration
REQ-027 SHALL, with macro ALGO_2RW_SCHED_STALL_CNT_EN defined, increment stall_cnt by 1 per cycle in which REQ-016 withholds a grant, saturating at 16'hFFFF.
REQ-028 SHALL, without ALGO_2RW_SCHED_STALL_CNT_EN, drive stall_cnt constant 0 and instantiate no counter logic.

Verification
REQ-029 SHALL cover: after reset, req_vld=4'b1111 all reads, addrs 1..4 -> cycle0 grants req0(A), req1(B); cycle1 req2(A), req3(B); pointer back to 0.
REQ-030 SHALL cover: SRAM_DELAY=1, req2 reads addr 0x10 at cycle 5, t1_doutA=0xDEADBEEF -> t1_readA=1 at cycle 6, rsp_vld=4'b0100 with rsp_dout[95:64]=0xDEADBEEF at cycle 7.
REQ-031 SHALL cover: req0 write and req1 read both addr 0x20, pointer 0 -> req_rdy=4'b0001, req1 granted next cycle, stall_cnt=1 with macro, 0 without.
REQ-032 SHALL cover: req1 and req3 reads same addr 0x30 -> both granted same cycle (no conflict on read/read).
REQ-033 SHALL cover: read accepted, rst pulsed for 1 cycle before response -> no rsp_vld, all t1 controls 0 during reset.
REQ-034 SHALL cover: 70000 forced conflict cycles with macro defined -> stall_cnt holds 16'hFFFF.
